alu_control: RTL and testbench
==============================

ALU_CONTROL -- requirements
Module: alu_control

Interface
REQ-001 The block SHALL have parameter ILLEGAL_CTRL, default 4'b1111, which is the aluctrl code driven for any unsupported alu_op/funct combination.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 The block SHALL have port in_valid, input, 1 bit: funct/alu_op are to be decoded this cycle.
REQ-005 The block SHALL have port funct, input, 6 bits: R-type instruction funct field.
REQ-006 The block SHALL have port alu_op, input, 2 bits: main-control ALU class.
REQ-007 The block SHALL have port aluctrl, output, 4 bits: registered ALU operation code.
REQ-008 The block SHALL have port out_valid, output, 1 bit: aluctrl holds the decode of an accepted request.
REQ-009 The block SHALL have port illegal, output, 1 bit: the accepted request was unsupported.

Function
REQ-010 The block SHALL use these ALU codes: AND 0000, OR 0001, ADD 0010, XOR 0011, SUB 0110, SLT 0111, SLTU 1000, NOR 1100.
REQ-011 When alu_op=00 (load/store), the block SHALL decode ADD, ignoring funct.
REQ-012 When alu_op=01 (branch), the block SHALL decode SUB, ignoring funct.
REQ-013 When alu_op=10 (R-type), the block SHALL decode by funct:
  - 100000 add -> ADD; 100001 addu -> ADD
  - 100010 sub -> SUB; 100011 subu -> SUB
  - 100100 and -> AND; 100101 or -> OR
  - 100110 xor -> XOR; 100111 nor -> NOR
  - 101010 slt -> SLT; 101011 sltu -> SLTU
REQ-014 For alu_op=10 with any other funct, or for alu_op=11, the block SHALL decode ILLEGAL_CTRL with illegal=1.
REQ-015 For every legal decode, the block SHALL set illegal=0.
REQ-016 Latency SHALL be exactly one clock: a request sampled with in_valid=1 at edge N appears on aluctrl/illegal with out_valid=1 after edge N.
REQ-017 On a cycle with in_valid=0, the block SHALL drive out_valid=0 after the edge and SHALL hold aluctrl and illegal at their previous values.
REQ-018 Back-to-back valid requests SHALL be accepted every cycle with no stall; there is no back-pressure.
REQ-019 Decoding SHALL be a pure function of the sampled alu_op/funct; no history affects the result.
REQ-020 X or unlisted inputs SHALL never propagate as X: the decode default is the illegal branch.

Reset
REQ-021 While rst_n=0, independent of clk, the block SHALL force aluctrl=0000, out_valid=0 and illegal=0.
REQ-022 On the first rising clk edge after rst_n returns high, the block SHALL perform normal sampling.
REQ-023 Assertion of rst_n mid-stream SHALL discard any in-flight result, and no output SHALL appear for a request sampled during reset.

Structure
REQ-024 The ALU code constants (REQ-010), the alu_op class encodings (00/01/10/11) and the funct encodings SHALL live in a shared package alu_pkg, also imported by the ALU.
REQ-025 The design SHALL consist of one combinational sub-module, alu_decode (funct, alu_op -> ctrl, illegal), plus an output register stage in alu_control.

Verification
REQ-026 Reset scenario: hold rst_n=0 with random inputs -> aluctrl=0000, out_valid=0, illegal=0 asynchronously.
REQ-027 Class-override scenario: funct=100000 with alu_op=00, then 01, then 10 -> aluctrl 0010, 0110, 0010 on consecutive cycles, illegal=0.
REQ-028 R-type sweep scenario: alu_op=10 with funct 100010/100100/100101/101010/100111 back-to-back -> 0110/0000/0001/0111/1100, one per cycle.
REQ-029 Illegal scenario: alu_op=10 with funct=000000, then alu_op=11 with funct=100000 -> aluctrl=1111 and illegal=1 on both.
REQ-030 Hold scenario: valid ADD, then in_valid=0 for 3 cycles -> out_valid=0 and aluctrl stays 0010.
REQ-031 Mid-stream reset scenario: assert rst_n low between two valid requests -> outputs clear immediately, and the second request yields its result only if sampled after release.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU encodings: operation codes, main-control ALU classes and R-type funct values.
// Imported by the ALU control path and the ALU datapath so both agree on every code.
package alu_pkg;

    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_XOR  = 4'b0011;
    localparam logic [3:0] ALU_SUB  = 4'b0110;
    localparam logic [3:0] ALU_SLT  = 4'b0111;
    localparam logic [3:0] ALU_SLTU = 4'b1000;
    localparam logic [3:0] ALU_NOR  = 4'b1100;

    localparam logic [1:0] OP_LDST   = 2'b00;
    localparam logic [1:0] OP_BRANCH = 2'b01;
    localparam logic [1:0] OP_RTYPE  = 2'b10;
    localparam logic [1:0] OP_RSVD   = 2'b11;

    localparam logic [5:0] FN_ADD  = 6'b100000;
    localparam logic [5:0] FN_ADDU = 6'b100001;
    localparam logic [5:0] FN_SUB  = 6'b100010;
    localparam logic [5:0] FN_SUBU = 6'b100011;
    localparam logic [5:0] FN_AND  = 6'b100100;
    localparam logic [5:0] FN_OR   = 6'b100101;
    localparam logic [5:0] FN_XOR  = 6'b100110;
    localparam logic [5:0] FN_NOR  = 6'b100111;
    localparam logic [5:0] FN_SLT  = 6'b101010;
    localparam logic [5:0] FN_SLTU = 6'b101011;

endpackage

// File: rtl/alu_decode.sv
// Combinational ALU-control decode: main-control class plus funct field to ALU operation code.
// Anything not explicitly recognised, including X inputs, falls into the illegal default.
module alu_decode
    import alu_pkg::*;
#(
    parameter logic [3:0] ILLEGAL_CTRL = 4'b1111
) (
    input  logic [5:0] funct,
    input  logic [1:0] alu_op,
    output logic [3:0] ctrl,
    output logic       illegal
);

    always_comb begin
        ctrl    = ILLEGAL_CTRL;
        illegal = 1'b1;
        case (alu_op)
            OP_LDST: begin
                ctrl    = ALU_ADD;
                illegal = 1'b0;
            end
            OP_BRANCH: begin
                ctrl    = ALU_SUB;
                illegal = 1'b0;
            end
            OP_RTYPE: begin
                illegal = 1'b0;
                case (funct)
                    FN_ADD, FN_ADDU: ctrl = ALU_ADD;
                    FN_SUB, FN_SUBU: ctrl = ALU_SUB;
                    FN_AND:          ctrl = ALU_AND;
                    FN_OR:           ctrl = ALU_OR;
                    FN_XOR:          ctrl = ALU_XOR;
                    FN_NOR:          ctrl = ALU_NOR;
                    FN_SLT:          ctrl = ALU_SLT;
                    FN_SLTU:         ctrl = ALU_SLTU;
                    default: begin
                        ctrl    = ILLEGAL_CTRL;
                        illegal = 1'b1;
                    end
                endcase
            end
            default: begin
                ctrl    = ILLEGAL_CTRL;
                illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/alu_control.sv
// ALU control unit: one-cycle registered decode of alu_op/funct with a valid flag.
// Idle cycles drop out_valid but keep the last decoded code and illegal flag visible.
module alu_control
    import alu_pkg::*;
#(
    parameter logic [3:0] ILLEGAL_CTRL = 4'b1111
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    input  logic [5:0] funct,
    input  logic [1:0] alu_op,
    output logic [3:0] aluctrl,
    output logic       out_valid,
    output logic       illegal
);

    logic [3:0] w_ctrl;
    logic       w_illegal;

    logic [3:0] r_aluctrl;
    logic       r_out_valid;
    logic       r_illegal;

    alu_decode #(
        .ILLEGAL_CTRL(ILLEGAL_CTRL)
    ) u_decode (
        .funct  (funct),
        .alu_op (alu_op),
        .ctrl   (w_ctrl),
        .illegal(w_illegal)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_aluctrl   <= 4'b0000;
            r_out_valid <= 1'b0;
            r_illegal   <= 1'b0;
        end else begin
            r_out_valid <= in_valid;
            if (in_valid) begin
                r_aluctrl <= w_ctrl;
                r_illegal <= w_illegal;
            end
        end
    end

    assign aluctrl   = r_aluctrl;
    assign out_valid = r_out_valid;
    assign illegal   = r_illegal;

endmodule

// File: tb/tb_alu_control.sv
// Scoreboard bench for alu_control: directed scenarios plus random traffic against a table-driven model.
// The driver queues one expected entry per sampled clock edge; the monitor pops and compares on the falling edge.
module tb_alu_control;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic [5:0] funct;
    logic [1:0] alu_op;
    logic [3:0] aluctrl;
    logic       out_valid;
    logic       illegal;

    typedef struct {
        logic       valid;
        logic [3:0] ctrl;
        logic       ill;
        logic [1:0] op;
        logic [5:0] fn;
    } exp_t;

    exp_t       exp_q[$];
    int         checks = 0;
    int         errors = 0;
    logic [3:0] last_ctrl = 4'b0000;
    logic       last_ill = 1'b0;
    logic [3:0] rtype_map [logic [5:0]];
    logic [5:0] legal_fn [10];

    alu_control #(
        .ILLEGAL_CTRL(4'b1111)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .funct    (funct),
        .alu_op   (alu_op),
        .aluctrl  (aluctrl),
        .out_valid(out_valid),
        .illegal  (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %b, expected %b at %0t", name, act, req, $time);
        end
    endtask

    // Reference model: class rules first, then a funct lookup table for R-type.
    function automatic void ref_decode(input logic [1:0] op, input logic [5:0] fn,
                                       output logic [3:0] ctrl, output logic ill);
        ctrl = 4'b1111;
        ill  = 1'b1;
        if (op == 2'd0) begin
            ctrl = 4'b0010; ill = 1'b0;
        end else if (op == 2'd1) begin
            ctrl = 4'b0110; ill = 1'b0;
        end else if (op == 2'd2 && rtype_map.exists(fn)) begin
            ctrl = rtype_map[fn]; ill = 1'b0;
        end
    endfunction

    // Apply inputs, let one rising edge sample them, and record what that edge should produce.
    task automatic step(input logic v, input logic [1:0] op, input logic [5:0] fn);
        exp_t e;
        in_valid = v;
        alu_op   = op;
        funct    = fn;
        @(posedge clk);
        if (rst_n) begin
            e.valid = v;
            e.op    = op;
            e.fn    = fn;
            ref_decode(op, fn, e.ctrl, e.ill);
            exp_q.push_back(e);
        end
        #1;
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            check("reset_aluctrl", aluctrl, 4'b0000);
            check("reset_out_valid", {3'b000, out_valid}, 4'b0000);
            check("reset_illegal", {3'b000, illegal}, 4'b0000);
            last_ctrl = 4'b0000;
            last_ill  = 1'b0;
        end else if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            check("out_valid", {3'b000, out_valid}, {3'b000, e.valid});
            if (e.valid) begin
                check("aluctrl", aluctrl, e.ctrl);
                check("illegal", {3'b000, illegal}, {3'b000, e.ill});
                last_ctrl = e.ctrl;
                last_ill  = e.ill;
                $display("txn op=%b funct=%b -> aluctrl=%b illegal=%b", e.op, e.fn, aluctrl, illegal);
            end else begin
                check("hold_aluctrl", aluctrl, last_ctrl);
                check("hold_illegal", {3'b000, illegal}, {3'b000, last_ill});
            end
        end
    end

    initial begin
        rtype_map[6'b100000] = 4'b0010;
        rtype_map[6'b100001] = 4'b0010;
        rtype_map[6'b100010] = 4'b0110;
        rtype_map[6'b100011] = 4'b0110;
        rtype_map[6'b100100] = 4'b0000;
        rtype_map[6'b100101] = 4'b0001;
        rtype_map[6'b100110] = 4'b0011;
        rtype_map[6'b100111] = 4'b1100;
        rtype_map[6'b101010] = 4'b0111;
        rtype_map[6'b101011] = 4'b1000;
        legal_fn = '{6'b100000, 6'b100001, 6'b100010, 6'b100011, 6'b100100,
                     6'b100101, 6'b100110, 6'b100111, 6'b101010, 6'b101011};

        // Reset held with random inputs toggling underneath.
        rst_n    = 1'b0;
        in_valid = 1'b0;
        alu_op   = 2'b00;
        funct    = 6'b000000;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'($urandom);
            alu_op   = 2'($urandom);
            funct    = 6'($urandom);
            @(posedge clk);
            #1;
        end
        rst_n = 1'b1;

        // Class override: same funct, ADD / SUB / ADD.
        step(1'b1, 2'b00, 6'b100000);
        step(1'b1, 2'b01, 6'b100000);
        step(1'b1, 2'b10, 6'b100000);

        // R-type sweep back-to-back.
        step(1'b1, 2'b10, 6'b100010);
        step(1'b1, 2'b10, 6'b100100);
        step(1'b1, 2'b10, 6'b100101);
        step(1'b1, 2'b10, 6'b101010);
        step(1'b1, 2'b10, 6'b100111);

        // Illegal combinations.
        step(1'b1, 2'b10, 6'b000000);
        step(1'b1, 2'b11, 6'b100000);

        // Valid ADD then three idle cycles with garbage on the inputs.
        step(1'b1, 2'b00, 6'b010101);
        step(1'b0, 2'b11, 6'b000000);
        step(1'b0, 2'b10, 6'b111111);
        step(1'b0, 2'b01, 6'b100010);

        // Mid-stream reset: result on the outputs must clear at once, and a request
        // sampled while in reset produces nothing.
        step(1'b1, 2'b10, 6'b101011);
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        check("async_clear_aluctrl", aluctrl, 4'b0000);
        check("async_clear_valid", {3'b000, out_valid}, 4'b0000);
        check("async_clear_illegal", {3'b000, illegal}, 4'b0000);
        step(1'b1, 2'b10, 6'b100110);
        step(1'b1, 2'b10, 6'b100110);
        rst_n = 1'b1;
        step(1'b1, 2'b10, 6'b100110);
        step(1'b0, 2'b00, 6'b000000);

        // Random traffic, biased toward legal funct codes.
        for (int i = 0; i < 300; i++) begin
            logic [5:0] fn;
            if ($urandom_range(0, 1) == 0) fn = legal_fn[$urandom_range(0, 9)];
            else fn = 6'($urandom);
            step(($urandom_range(0, 9) < 7) ? 1'b1 : 1'b0, 2'($urandom), fn);
        end

        step(1'b0, 2'b00, 6'b000000);
        step(1'b0, 2'b00, 6'b000000);
        @(negedge clk);
        #1;
        check("scoreboard_drained", 4'(exp_q.size()), 4'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
